// File: rtl/srl_chain_checker.sv
// -----------------------------------------------------------------------------
// srl_chain_checker
//
// Stimulus/response engine for testing shift-register chains. A 16-bit
// Fibonacci LFSR drives a pseudo-random pattern into LANES chains under test.
// A DEPTH-stage reference pipeline, fed from the same pattern, predicts what
// each chain should emit. Once the reference is full, every enabled cycle
// compares the chain outputs against the reference tail. Disagreements set
// sticky per-lane flags and bump a saturating mismatch-cycle counter.
//
// Ports:
//   clk         in   1      single clock
//   rst_n       in   1      asynchronous active-low reset
//   en          in   1      advance enable; every piece of state holds when low
//   err_clr     in   1      synchronous clear of error, err_cnt and armed
//   chain_ce    out  1      shift enable for the chains (equal to en)
//   chain_din   out  LANES  pattern into the chains (low LFSR bits, registered)
//   chain_dout  in   LANES  last-stage outputs of the chains
//   armed       out  1      comparison active
//   error       out  LANES  sticky per-lane mismatch flags
//   err_cnt     out  16     saturating count of cycles with any mismatch
// -----------------------------------------------------------------------------
module srl_chain_checker #(
    parameter int          LANES = 8,
    parameter int          DEPTH = 16,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             err_clr,
    output logic             chain_ce,
    output logic [LANES-1:0] chain_din,
    input  logic [LANES-1:0] chain_dout,
    output logic             armed,
    output logic [LANES-1:0] error,
    output logic [15:0]      err_cnt
);

    localparam int FW = $clog2(DEPTH + 1);

    // -------------------------------------------------------------------------
    // Pattern generator: x^16 + x^14 + x^13 + x^11 + 1, shifting left with the
    // feedback entering bit 0. The register doubles as the chain input, so
    // chain_din changes only after an enabled edge.
    // -------------------------------------------------------------------------
    logic [15:0] lfsr_reg;
    logic        feedback;

    assign feedback = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= SEED;
        end else if (en) begin
            lfsr_reg <= {lfsr_reg[14:0], feedback};
        end
    end

    assign chain_din = lfsr_reg[LANES-1:0];
    assign chain_ce  = en;

    // -------------------------------------------------------------------------
    // Reference delay line. It shifts on exactly the same edges as the chains
    // and captures the same chain_din, so an ideal chain output always equals
    // the tail stage, including across stalls.
    // -------------------------------------------------------------------------
    logic [LANES-1:0] ref_reg [DEPTH];
    logic [LANES-1:0] ref_tail;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ref
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ref_reg[gi] <= '0;
                    end else if (en) begin
                        ref_reg[gi] <= chain_din;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ref_reg[gi] <= '0;
                    end else if (en) begin
                        ref_reg[gi] <= ref_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign ref_tail = ref_reg[DEPTH-1];

    // -------------------------------------------------------------------------
    // Fill tracking. The reference only holds meaningful data once DEPTH
    // enabled edges have passed since reset or err_clr, so armed rises on the
    // edge that brings the fill count to DEPTH. err_clr restarts the fill,
    // which keeps the comparison off until the pipeline has refilled.
    // -------------------------------------------------------------------------
    logic [FW-1:0] fill_reg;
    logic          armed_reg;
    logic          fill_full;

    assign fill_full = (fill_reg == FW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_reg  <= '0;
            armed_reg <= 1'b0;
        end else if (err_clr) begin
            fill_reg  <= '0;
            armed_reg <= 1'b0;
        end else if (en) begin
            if (!fill_full) begin
                fill_reg <= fill_reg + FW'(1);
            end
            // Covers both the completing edge (fill = DEPTH-1) and staying full.
            armed_reg <= (fill_reg >= FW'(DEPTH - 1));
        end
    end

    assign armed = armed_reg;

    // -------------------------------------------------------------------------
    // Comparison and sticky reporting. err_clr wins over a mismatch sampled on
    // the same edge.
    // -------------------------------------------------------------------------
    logic             do_compare;
    logic [LANES-1:0] mismatch;
    logic [LANES-1:0] error_reg;
    logic [15:0]      err_cnt_reg;

    assign do_compare = en & armed_reg;
    assign mismatch   = chain_dout ^ ref_tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_reg   <= '0;
            err_cnt_reg <= '0;
        end else if (err_clr) begin
            error_reg   <= '0;
            err_cnt_reg <= '0;
        end else if (do_compare) begin
            error_reg <= error_reg | mismatch;
            if ((|mismatch) && (err_cnt_reg != 16'hFFFF)) begin
                err_cnt_reg <= err_cnt_reg + 16'd1;
            end
        end
    end

    assign error   = error_reg;
    assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_srl_chain_checker.sv
// -----------------------------------------------------------------------------
// tb_srl_chain_checker
//
// Drives srl_chain_checker (LANES=8, DEPTH=16) with a behavioural chain under
// test: a 16-stage register on chain_ce that can be shortened to 15 stages or
// have lane 3 stuck at 0. Directed phases use hand-computed constants (the
// LFSR start sequence, arming edge counts, expected flag patterns); a small
// scoreboard tracks the expected outputs cycle by cycle.
// -----------------------------------------------------------------------------
module tb_srl_chain_checker;

    localparam int LANES = 8;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        err_clr = 1'b0;
    logic        chain_ce;
    logic [7:0]  chain_din;
    logic [7:0]  chain_dout;
    logic        armed;
    logic [7:0]  error;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;

    // First chain_din values after reset, worked out by hand from SEED 16'hACE1:
    // ACE1 -> 59C3 -> B387 -> 670F -> CE1E
    logic [7:0] seq_exp [5] = '{8'hE1, 8'hC3, 8'h87, 8'h0F, 8'h1E};

    always #5 clk = ~clk;

    srl_chain_checker #(
        .LANES (LANES),
        .DEPTH (DEPTH),
        .SEED  (16'hACE1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .err_clr    (err_clr),
        .chain_ce   (chain_ce),
        .chain_din  (chain_din),
        .chain_dout (chain_dout),
        .armed      (armed),
        .error      (error),
        .err_cnt    (err_cnt)
    );

    // ---------------- behavioural chain under test ----------------
    logic       stuck = 1'b0;
    logic       short_chain = 1'b0;
    logic [7:0] chain_q [16];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) chain_q[i] <= '0;
        end else if (chain_ce) begin
            chain_q[0] <= chain_din;
            for (int i = 1; i < 16; i++) chain_q[i] <= chain_q[i-1];
        end
    end

    assign chain_dout = (short_chain ? chain_q[14] : chain_q[15]) &
                        (stuck ? 8'hF7 : 8'hFF);

    // ---------------- scoreboard ----------------
    logic [15:0] m_lfsr;
    logic [7:0]  m_hist [16];
    int          m_fill;
    logic        m_armed;
    logic [7:0]  m_err;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        for (int i = 0; i < 16; i++) m_hist[i] = '0;
        m_fill  = 0;
        m_armed = 1'b0;
        m_err   = '0;
        m_cnt   = '0;
    endtask

    // One clock cycle: called just after a negedge with inputs already set.
    task automatic tick();
        logic [15:0] n_lfsr;
        logic [7:0]  mm;
        logic [7:0]  n_err;
        logic [15:0] n_cnt;
        int          n_fill;
        logic        n_armed;
        #1;
        n_lfsr  = m_lfsr;
        n_err   = m_err;
        n_cnt   = m_cnt;
        n_fill  = m_fill;
        n_armed = m_armed;
        mm = chain_dout ^ m_hist[15];
        if (en) n_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        if (err_clr) begin
            n_err = '0; n_cnt = '0; n_fill = 0; n_armed = 1'b0;
        end else if (en) begin
            if (m_armed) begin
                n_err = n_err | mm;
                if (mm != 8'h00 && m_cnt != 16'hFFFF) n_cnt = m_cnt + 16'd1;
            end
            if (m_fill < DEPTH) n_fill = m_fill + 1;
            n_armed = (n_fill == DEPTH);
        end
        @(posedge clk);
        if (en) begin
            for (int i = 15; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = m_lfsr[7:0];
        end
        m_lfsr  = n_lfsr;
        m_err   = n_err;
        m_cnt   = n_cnt;
        m_fill  = n_fill;
        m_armed = n_armed;
        @(negedge clk);
        check("din",   chain_din, m_lfsr[7:0]);
        check("armed", armed,     m_armed);
        check("error", error,     m_err);
        check("cnt",   err_cnt,   m_cnt);
    endtask

    initial begin
        logic [7:0] prev_din;
        int         en_edges;

        // ---- reset state ----
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_din",   chain_din, 8'hE1);
        check("rst_armed", armed,     1'b0);
        check("rst_error", error,     8'h00);
        check("rst_cnt",   err_cnt,   16'h0000);
        check("rst_ce",    chain_ce,  1'b0);
        $display("reset: din=%h armed=%b error=%h cnt=%0d", chain_din, armed, error, err_cnt);

        // ---- start sequence and arming ----
        rst_n = 1'b1;
        en    = 1'b1;
        #1 check("ce_follows_en", chain_ce, 1'b1);
        for (int k = 1; k < 5; k++) begin
            tick();
            check("seq", chain_din, seq_exp[k]);
        end
        repeat (11) tick();
        check("arm_15", armed, 1'b0);
        tick();
        check("arm_16", armed, 1'b1);
        $display("start: sequence and arming after 16 enabled edges");

        // ---- ideal chain ----
        repeat (1000) tick();
        check("ideal_err", error,   8'h00);
        check("ideal_cnt", err_cnt, 16'h0000);
        $display("ideal: error=%h cnt=%0d", error, err_cnt);

        // ---- lane 3 stuck at 0 ----
        stuck = 1'b1;
        repeat (60) tick();
        check("stuck_err",   error,          8'h08);
        check("stuck_cntnz", (err_cnt != 0), 1'b1);
        $display("stuck: error=%h cnt=%0d", error, err_cnt);

        // ---- err_clr while faulty, then fault removed ----
        err_clr = 1'b1;
        stuck   = 1'b0;
        tick();
        err_clr = 1'b0;
        check("clr_err",   error,   8'h00);
        check("clr_cnt",   err_cnt, 16'h0000);
        check("clr_armed", armed,   1'b0);
        repeat (15) tick();
        check("rearm_15", armed, 1'b0);
        tick();
        check("rearm_16", armed, 1'b1);
        repeat (50) tick();
        check("clean_err", error, 8'h00);
        $display("clear: rearmed and clean, error=%h cnt=%0d", error, err_cnt);

        // ---- random enable with ideal chain ----
        err_clr = 1'b1;
        tick();
        err_clr  = 1'b0;
        en_edges = 0;
        for (int n = 0; n < 300; n++) begin
            en = 1'($urandom_range(0, 1));
            prev_din = chain_din;
            tick();
            if (!en) check("hold", chain_din, prev_din);
            else en_edges++;
            check("arm_rule", armed, (en_edges >= 16));
        end
        en = 1'b1;
        check("rand_err", error,   8'h00);
        check("rand_cnt", err_cnt, 16'h0000);
        $display("random en: %0d enabled edges, error=%h", en_edges, error);

        // ---- chain one stage short ----
        repeat (16) tick();
        short_chain = 1'b1;
        repeat (40) tick();
        check("short_cntnz", (err_cnt != 0),        1'b1);
        check("short_lanes", ($countones(error) >= 2), 1'b1);
        $display("short chain: error=%h cnt=%0d", error, err_cnt);

        // ---- asynchronous reset mid-run ----
        #2 rst_n = 1'b0;
        #1;
        check("async_din",   chain_din, 8'hE1);
        check("async_armed", armed,     1'b0);
        check("async_error", error,     8'h00);
        check("async_cnt",   err_cnt,   16'h0000);
        model_reset();
        short_chain = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            check("reseq", chain_din, seq_exp[k]);
        end
        repeat (11) tick();
        check("rst_arm_15", armed, 1'b0);
        tick();
        check("rst_arm_16", armed, 1'b1);
        repeat (100) tick();
        check("post_rst_err", error, 8'h00);
        $display("mid-run reset: sequence restarted, error=%h", error);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
